activation_ring: RTL and testbench

ACTIVATION_RING -- requirements
Module: activation_ring

---
 rtl/activation_ring_pkg.sv | 14 +
 rtl/activation_ring_ram.sv | 30 +++
 rtl/activation_ring.sv | 102 ++++++++++
 tb/tb_activation_ring.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/activation_ring_pkg.sv
// Shared network constants for the conv1d activation pipeline: element width,
// vector length, per-layer dilations and the packed activation vector type.
package activation_ring_pkg;

  localparam int NET_W = 16;
  localparam int NET_D = 8;

  localparam int CONV0_DILATION = 4;
  localparam int CONV1_DILATION = 16;
  localparam int CONV2_DILATION = 64;

  typedef logic signed [NET_D*NET_W-1:0] act_vec_t;

endpackage

// File: rtl/activation_ring_ram.sv
// History storage for activation_ring: one synchronous write port and three
// asynchronous read ports, no reset (maps onto LUTRAM).
module activation_ring_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  input  logic [AW-1:0]    raddr3,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic [WIDTH-1:0] rdata3
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign rdata3 = mem[raddr3];

endmodule

// File: rtl/activation_ring.sv
// Dilated history buffer between conv1d layers: presents the newest activation
// plus those DILATION, 2*DILATION and 3*DILATION pushes back as registered taps.
module activation_ring
  import activation_ring_pkg::*;
#(
  parameter int W        = NET_W,
  parameter int D        = NET_D,
  parameter int DILATION = CONV0_DILATION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  flush,
  input  logic signed [D*W-1:0] inp,
  output logic signed [D*W-1:0] out_l0,
  output logic signed [D*W-1:0] out_l1,
  output logic signed [D*W-1:0] out_l2,
  output logic signed [D*W-1:0] out_l3,
  output logic                  out_v,
  output logic                  primed
);

  localparam int DEPTH = 3*DILATION + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] OFF1      = CW'(DILATION);
  localparam logic [CW-1:0] OFF2      = CW'(2*DILATION);
  localparam logic [CW-1:0] OFF3      = CW'(3*DILATION);

  logic [AW-1:0]    wptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [D*W-1:0]   rd1, rd2, rd3;
  logic             wr_en;

  // Slot holding the vector pushed 'off' pushes before the one now at wptr.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] wp, input int off);
    int sum;
    sum = int'(wp) + DEPTH - off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return AW'(sum);
  endfunction

  assign wr_en   = push && !flush;
  assign cnt_inc = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);

  activation_ring_ram #(
    .WIDTH (D*W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .waddr  (wptr),
    .wdata  (inp),
    .raddr1 (tap_addr(wptr, DILATION)),
    .raddr2 (tap_addr(wptr, 2*DILATION)),
    .raddr3 (tap_addr(wptr, 3*DILATION)),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .rdata3 (rd3)
  );

  // Taps are captured in the push cycle; the newest comes straight from inp
  // and older ones are masked to zero until that many pushes have occurred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      cnt    <= '0;
      out_l0 <= '0;
      out_l1 <= '0;
      out_l2 <= '0;
      out_l3 <= '0;
      out_v  <= 1'b0;
      primed <= 1'b0;
    end else if (flush) begin
      wptr   <= '0;
      cnt    <= '0;
      out_l0 <= '0;
      out_l1 <= '0;
      out_l2 <= '0;
      out_l3 <= '0;
      out_v  <= 1'b0;
      primed <= 1'b0;
    end else begin
      out_v <= push;
      if (push) begin
        wptr   <= (wptr == WPTR_LAST) ? '0 : wptr + AW'(1);
        cnt    <= cnt_inc;
        primed <= (cnt_inc == CNT_FULL);
        out_l3 <= inp;
        out_l2 <= (cnt >= OFF1) ? rd1 : '0;
        out_l1 <= (cnt >= OFF2) ? rd2 : '0;
        out_l0 <= (cnt >= OFF3) ? rd3 : '0;
      end
    end
  end

endmodule

// File: tb/tb_activation_ring.sv
// Directed bench for activation_ring at default parameters (W=16, D=8, DILATION=4).
module tb_activation_ring;

  logic         clk;
  logic         rst;
  logic         push;
  logic         flush;
  logic signed [127:0] inp;
  logic signed [127:0] out_l0, out_l1, out_l2, out_l3;
  logic         out_v;
  logic         primed;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] hist[$];

  activation_ring dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .flush  (flush),
    .inp    (inp),
    .out_l0 (out_l0),
    .out_l1 (out_l1),
    .out_l2 (out_l2),
    .out_l3 (out_l3),
    .out_v  (out_v),
    .primed (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] l3, l2, l1, l0;
    logic        primed;
  } row_t;

  row_t tbl[13];

  // Element 0 carries the tag; other elements are distinct patterns derived from it.
  function automatic activation_ring_pkg::act_vec_t mkvec(input logic [15:0] e0);
    activation_ring_pkg::act_vec_t v;
    for (int j = 0; j < 8; j++)
      v[j*16 +: 16] = (j == 0) ? e0 : (e0 ^ 16'(16'h1111 * j));
    return v;
  endfunction

  function automatic logic [127:0] ev(input logic [15:0] e0);
    return (e0 == 16'h0) ? 128'h0 : mkvec(e0);
  endfunction

  function automatic logic [127:0] mtap(input int off);
    if (hist.size() > off) return mkvec(hist[hist.size() - 1 - off]);
    return 128'h0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag, input logic exp_v);
    chk({tag, ".out_v"},  128'(out_v), 128'(exp_v));
    chk({tag, ".l3"},     out_l3, mtap(0));
    chk({tag, ".l2"},     out_l2, mtap(4));
    chk({tag, ".l1"},     out_l1, mtap(8));
    chk({tag, ".l0"},     out_l0, mtap(12));
    chk({tag, ".primed"}, 128'(primed), 128'(hist.size() >= 13));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".l3"},     out_l3, 128'h0);
    chk({tag, ".l2"},     out_l2, 128'h0);
    chk({tag, ".l1"},     out_l1, 128'h0);
    chk({tag, ".l0"},     out_l0, 128'h0);
    chk({tag, ".out_v"},  128'(out_v), 128'h0);
    chk({tag, ".primed"}, 128'(primed), 128'h0);
  endtask

  task automatic do_push(input logic [15:0] e0);
    @(negedge clk);
    inp  = mkvec(e0);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    hist.push_back(e0);
  endtask

  initial begin
    // e0 pushed, then expected e0 of l3, l2, l1, l0 (0 = all-zero tap), primed
    tbl[0]  = '{16'd1,  16'd1,  16'd0, 16'd0, 16'd0, 1'b0};
    tbl[1]  = '{16'd2,  16'd2,  16'd0, 16'd0, 16'd0, 1'b0};
    tbl[2]  = '{16'd3,  16'd3,  16'd0, 16'd0, 16'd0, 1'b0};
    tbl[3]  = '{16'd4,  16'd4,  16'd0, 16'd0, 16'd0, 1'b0};
    tbl[4]  = '{16'd5,  16'd5,  16'd1, 16'd0, 16'd0, 1'b0};
    tbl[5]  = '{16'd6,  16'd6,  16'd2, 16'd0, 16'd0, 1'b0};
    tbl[6]  = '{16'd7,  16'd7,  16'd3, 16'd0, 16'd0, 1'b0};
    tbl[7]  = '{16'd8,  16'd8,  16'd4, 16'd0, 16'd0, 1'b0};
    tbl[8]  = '{16'd9,  16'd9,  16'd5, 16'd1, 16'd0, 1'b0};
    tbl[9]  = '{16'd10, 16'd10, 16'd6, 16'd2, 16'd0, 1'b0};
    tbl[10] = '{16'd11, 16'd11, 16'd7, 16'd3, 16'd0, 1'b0};
    tbl[11] = '{16'd12, 16'd12, 16'd8, 16'd4, 16'd0, 1'b0};
    tbl[12] = '{16'd13, 16'd13, 16'd9, 16'd5, 16'd1, 1'b1};

    rst = 1'b1; push = 1'b0; flush = 1'b0; inp = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle_after_reset");

    // Fill from empty: partial-fill masking through to primed
    for (int i = 0; i < 13; i++) begin
      do_push(tbl[i].e0);
      chk($sformatf("fill%0d.out_v", i + 1),  128'(out_v), 128'h1);
      chk($sformatf("fill%0d.l3", i + 1),     out_l3, ev(tbl[i].l3));
      chk($sformatf("fill%0d.l2", i + 1),     out_l2, ev(tbl[i].l2));
      chk($sformatf("fill%0d.l1", i + 1),     out_l1, ev(tbl[i].l1));
      chk($sformatf("fill%0d.l0", i + 1),     out_l0, ev(tbl[i].l0));
      chk($sformatf("fill%0d.primed", i + 1), 128'(primed), 128'(tbl[i].primed));
    end

    @(negedge clk);
    chk("hold.out_v", 128'(out_v), 128'h0);
    chk("hold.l3",    out_l3, mkvec(16'd13));
    chk("hold.l0",    out_l0, mkvec(16'd1));

    // Continue past the ring size to exercise wrap-around
    for (int k = 14; k <= 30; k++) begin
      do_push(16'(k));
      chk_model($sformatf("wrap%0d", k), 1'b1);
    end
    chk("wrap30.l3", out_l3, mkvec(16'd30));
    chk("wrap30.l2", out_l2, mkvec(16'd26));
    chk("wrap30.l1", out_l1, mkvec(16'd22));
    chk("wrap30.l0", out_l0, mkvec(16'd18));

    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    hist.delete();
    chk_zero("flush");

    for (int k = 1; k <= 13; k++) begin
      do_push(16'(k + 40));
      chk_model($sformatf("refill%0d", k), 1'b1);
    end

    // Push and flush together: flush must win
    @(negedge clk);
    inp = mkvec(16'd99); push = 1'b1; flush = 1'b1;
    @(negedge clk);
    push = 1'b0; flush = 1'b0;
    hist.delete();
    chk_zero("push_flush");
    do_push(16'h7FFF);
    chk_model("after_flush", 1'b1);
    chk("after_flush.l3_exact", out_l3, mkvec(16'h7FFF));

    for (int k = 1; k <= 10; k++) begin
      do_push(16'(k + 60));
      chk_model($sformatf("pre_rst%0d", k), 1'b1);
    end

    // Asynchronous reset pulse between clock edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    #1 rst = 1'b0;
    hist.delete();
    @(negedge clk);
    chk_zero("post_rst");
    do_push(16'hFFFF);
    chk_model("neg_one", 1'b1);
    chk("neg_one.l3_exact", out_l3, mkvec(16'hFFFF));

    // Back-to-back pushes, one per clock
    @(negedge clk);
    inp = mkvec(16'd100); push = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hist.push_back(16'(100 + i));
      if (i == 19) push = 1'b0;
      else inp = mkvec(16'(101 + i));
      chk_model($sformatf("b2b%0d", i), 1'b1);
    end
    @(negedge clk);
    chk("b2b_end.out_v", 128'(out_v), 128'h0);
    chk("b2b_end.l3",    out_l3, mkvec(16'd119));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
